// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction field positions and
// the fetch FSM state encoding.
package mips_pkg;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;

    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 26;
    localparam int unsigned RS_MSB   = 25;
    localparam int unsigned RS_LSB   = 21;
    localparam int unsigned RT_MSB   = 20;
    localparam int unsigned RT_LSB   = 16;
    localparam int unsigned RD_MSB   = 15;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned SH_MSB   = 10;
    localparam int unsigned SH_LSB   = 6;
    localparam int unsigned FN_MSB   = 5;
    localparam int unsigned FN_LSB   = 0;
    localparam int unsigned IMM_MSB  = 15;
    localparam int unsigned JIDX_MSB = 25;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StErr  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_reg_if.sv
// Control-unit / memory handshake and decoded-field bundle of the instruction
// register; slave is the IR side, master the surrounding datapath.
interface instr_fetch_reg_if;
    import mips_pkg::*;

    logic        ir_write;
    logic        flush;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_req;
    logic        busy;
    logic        ir_valid;
    logic        fetch_err;
    logic [31:0] ir_out;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [25:0] jump_index;
    logic [31:0] imm_ext;

    modport slave (
        input  ir_write, flush, mem_rdata, mem_rvalid,
        output mem_req, busy, ir_valid, fetch_err, ir_out,
        output opcode, rs, rt, rd, shamt, funct, jump_index, imm_ext
    );

    modport master (
        output ir_write, flush, mem_rdata, mem_rvalid,
        input  mem_req, busy, ir_valid, fetch_err, ir_out,
        input  opcode, rs, rt, rd, shamt, funct, jump_index, imm_ext
    );

endinterface

// File: rtl/imm_extender.sv
// 16-to-32-bit immediate extension: logical-immediate opcodes zero-extend,
// everything else sign-extends.
module imm_extender
    import mips_pkg::*;
(
    input  logic [15:0] i_imm,
    input  logic [5:0]  i_opcode,
    output logic [31:0] o_imm_ext
);

    always_comb begin
        case (i_opcode)
            OP_ANDI, OP_ORI, OP_XORI: o_imm_ext = {16'h0000, i_imm};
            default:                  o_imm_ext = {{16{i_imm[15]}}, i_imm};
        endcase
    end

endmodule

// File: rtl/instr_fetch_reg.sv
// Multicycle instruction register: issues one memory read per IRWrite, waits
// for the response under a timeout, latches the word and decodes its fields.
module instr_fetch_reg
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_fetch_reg_if.slave   bus
);

    fetch_state_e     r_state, w_state_d;
    logic             r_mem_req, w_mem_req_d;
    logic             r_busy, w_busy_d;
    logic             r_ir_valid, w_ir_valid_d;
    logic             r_fetch_err, w_fetch_err_d;
    logic [31:0]      r_ir, w_ir_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             w_timeout;
    logic [31:0]      w_imm_ext;

    // True when the current WAIT cycle is the last one allowed.
    assign w_timeout = (TIMEOUT != 0) && ((32'(r_cnt) + 32'd1) == TIMEOUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (bus.flush) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle:  if (bus.ir_write) w_state_d = StWait;
                StWait: begin
                    if (bus.mem_rvalid)  w_state_d = StIdle;
                    else if (w_timeout)  w_state_d = StErr;
                end
                StErr:   w_state_d = StErr;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        w_mem_req_d   = 1'b0;
        w_busy_d      = r_busy;
        w_ir_valid_d  = r_ir_valid;
        w_fetch_err_d = r_fetch_err;
        w_ir_d        = r_ir;
        w_cnt_d       = r_cnt;
        if (bus.flush) begin
            w_busy_d      = 1'b0;
            w_ir_valid_d  = 1'b0;
            w_fetch_err_d = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.ir_write) begin
                        w_mem_req_d  = 1'b1;
                        w_busy_d     = 1'b1;
                        w_ir_valid_d = 1'b0;
                        w_cnt_d      = '0;
                    end
                end
                StWait: begin
                    if (bus.mem_rvalid) begin
                        w_ir_d       = bus.mem_rdata;
                        w_ir_valid_d = 1'b1;
                        w_busy_d     = 1'b0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                        if (w_timeout) begin
                            w_fetch_err_d = 1'b1;
                            w_busy_d      = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_ir_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
            r_ir        <= '0;
            r_cnt       <= '0;
        end else begin
            r_mem_req   <= w_mem_req_d;
            r_busy      <= w_busy_d;
            r_ir_valid  <= w_ir_valid_d;
            r_fetch_err <= w_fetch_err_d;
            r_ir        <= w_ir_d;
            r_cnt       <= w_cnt_d;
        end
    end

    imm_extender u_imm_extender (
        .i_imm     (r_ir[IMM_MSB:0]),
        .i_opcode  (r_ir[OP_MSB:OP_LSB]),
        .o_imm_ext (w_imm_ext)
    );

    assign bus.mem_req    = r_mem_req;
    assign bus.busy       = r_busy;
    assign bus.ir_valid   = r_ir_valid;
    assign bus.fetch_err  = r_fetch_err;
    assign bus.ir_out     = r_ir;
    assign bus.opcode     = r_ir[OP_MSB:OP_LSB];
    assign bus.rs         = r_ir[RS_MSB:RS_LSB];
    assign bus.rt         = r_ir[RT_MSB:RT_LSB];
    assign bus.rd         = r_ir[RD_MSB:RD_LSB];
    assign bus.shamt      = r_ir[SH_MSB:SH_LSB];
    assign bus.funct      = r_ir[FN_MSB:FN_LSB];
    assign bus.jump_index = r_ir[JIDX_MSB:0];
    assign bus.imm_ext    = w_imm_ext;

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Scoreboard bench for instr_fetch_reg: stimulus pushes hand-computed expected
// fetch results, a monitor pops them on each ir_valid / fetch_err rise.
module tb_instr_fetch_reg;

    typedef struct {
        logic        is_err;
        logic [31:0] ir;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  fn;
        logic [31:0] imm;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errs   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;
    logic prev_err   = 1'b0;

    instr_fetch_reg_if bus ();

    instr_fetch_reg #(
        .TIMEOUT (4),
        .CNT_W   (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic push_exp(input logic is_err, input logic [31:0] ir, input logic [5:0] op,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [5:0] fn, input logic [31:0] imm);
        exp_t e;
        e.is_err = is_err; e.ir = ir; e.op = op; e.rs = rs;
        e.rt = rt; e.rd = rd; e.fn = fn; e.imm = imm;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at a negedge a couple of cycles after the load.
    task automatic do_fetch(input logic [31:0] data, input int dly);
        int mreq_cnt = 0;
        int busy_cnt = 0;
        bus.ir_write = 1'b1;
        @(negedge clk);
        bus.ir_write = 1'b0;
        for (int i = 0; i <= dly; i++) begin
            if (bus.mem_req) mreq_cnt++;
            if (bus.busy) busy_cnt++;
            if (i == dly) begin
                bus.mem_rdata  = data;
                bus.mem_rvalid = 1'b1;
            end
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (bus.mem_req) mreq_cnt++;
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        check("mem_req_pulses", 32'(mreq_cnt), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(dly + 1));
    endtask

    always @(negedge clk) begin
        if ((bus.ir_valid && !prev_valid) || (bus.fetch_err && !prev_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {bus.ir_valid, bus.fetch_err}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_fetch_err", 32'(bus.fetch_err), 32'(mon_e.is_err));
                check("sb_ir_out", bus.ir_out, mon_e.ir);
                if (!mon_e.is_err) begin
                    check("sb_opcode", 32'(bus.opcode), 32'(mon_e.op));
                    check("sb_rs", 32'(bus.rs), 32'(mon_e.rs));
                    check("sb_rt", 32'(bus.rt), 32'(mon_e.rt));
                    check("sb_rd", 32'(bus.rd), 32'(mon_e.rd));
                    check("sb_funct", 32'(bus.funct), 32'(mon_e.fn));
                    check("sb_imm_ext", bus.imm_ext, mon_e.imm);
                end else begin
                    check("sb_err_busy", 32'(bus.busy), 32'd0);
                end
            end
        end
        prev_valid <= bus.ir_valid;
        prev_err   <= bus.fetch_err;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc;
        reset_n        = 1'b0;
        bus.ir_write   = 1'b0;
        bus.flush      = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ir_out", bus.ir_out, 32'h0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
        check("rst_opcode", 32'(bus.opcode), 32'd0);
        check("rst_imm_ext", bus.imm_ext, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Responses while idle must be ignored.
        bus.mem_rdata  = 32'hDEADBEEF;
        bus.mem_rvalid = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        check("idle_rvalid_ir_out", bus.ir_out, 32'h0);
        check("idle_rvalid_valid", 32'(bus.ir_valid), 32'd0);

        push_exp(1'b0, 32'h2128FFFC, 6'h08, 5'd9, 5'd8, 5'd31, 6'h3C, 32'hFFFFFFFC);
        do_fetch(32'h2128FFFC, 2);
        push_exp(1'b0, 32'h3528FFFC, 6'h0D, 5'd9, 5'd8, 5'd31, 6'h3C, 32'h0000FFFC);
        do_fetch(32'h3528FFFC, 1);
        push_exp(1'b0, 32'h012A4020, 6'h00, 5'd9, 5'd10, 5'd8, 6'h20, 32'h00004020);
        do_fetch(32'h012A4020, 0);
        check("add_shamt", 32'(bus.shamt), 32'd0);
        check("add_jump_index", 32'(bus.jump_index), 32'h012A4020);
        // Response in the last allowed WAIT cycle still succeeds.
        push_exp(1'b0, 32'h30008001, 6'h0C, 5'd0, 5'd0, 5'd16, 6'h01, 32'h00008001);
        do_fetch(32'h30008001, 3);
        check("late_ok_no_err", 32'(bus.fetch_err), 32'd0);
        push_exp(1'b0, 32'h38008000, 6'h0E, 5'd0, 5'd0, 5'd16, 6'h00, 32'h00008000);
        do_fetch(32'h38008000, 0);
        push_exp(1'b0, 32'h28008000, 6'h0A, 5'd0, 5'd0, 5'd16, 6'h00, 32'hFFFF8000);
        do_fetch(32'h28008000, 1);
        repeat (3) @(negedge clk);
        check("valid_holds", 32'(bus.ir_valid), 32'd1);

        // Timeout with no response.
        push_exp(1'b1, 32'h28008000, 6'h0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0);
        bus.ir_write = 1'b1;
        @(negedge clk);
        bus.ir_write = 1'b0;
        check("accept_clears_valid", 32'(bus.ir_valid), 32'd0);
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.fetch_err) break;
            if (bus.busy) bc++;
            @(negedge clk);
        end
        check("timeout_err", 32'(bus.fetch_err), 32'd1);
        check("timeout_wait_cycles", 32'(bc), 32'd4);

        bus.ir_write   = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h11111111;
        @(negedge clk);
        bus.ir_write   = 1'b0;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        check("err_no_req", 32'(bus.mem_req), 32'd0);
        check("err_no_busy", 32'(bus.busy), 32'd0);
        check("err_sticky", 32'(bus.fetch_err), 32'd1);
        check("err_ir_kept", bus.ir_out, 32'h28008000);

        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_err_clr", 32'(bus.fetch_err), 32'd0);
        check("flush_valid_clr", 32'(bus.ir_valid), 32'd0);
        check("flush_ir_kept", bus.ir_out, 32'h28008000);

        push_exp(1'b0, 32'h8C000001, 6'h23, 5'd0, 5'd0, 5'd0, 6'h01, 32'h00000001);
        do_fetch(32'h8C000001, 1);

        // flush together with ir_write in IDLE: no fetch.
        bus.flush    = 1'b1;
        bus.ir_write = 1'b1;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.ir_write = 1'b0;
        check("flush_wr_no_req", 32'(bus.mem_req), 32'd0);
        check("flush_wr_no_busy", 32'(bus.busy), 32'd0);
        check("flush_wr_valid_clr", 32'(bus.ir_valid), 32'd0);

        // flush racing a response: data dropped.
        bus.ir_write = 1'b1;
        @(negedge clk);
        bus.ir_write   = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFEF00D;
        bus.flush      = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.flush      = 1'b0;
        check("race_valid", 32'(bus.ir_valid), 32'd0);
        check("race_busy", 32'(bus.busy), 32'd0);
        check("race_ir_kept", bus.ir_out, 32'h8C000001);

        // Reset mid-WAIT.
        bus.ir_write = 1'b1;
        @(negedge clk);
        bus.ir_write = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset_n        = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12345678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        check("post_reset_valid", 32'(bus.ir_valid), 32'd0);
        check("post_reset_ir", bus.ir_out, 32'h0);

        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
